// File: rtl/io_pkg.sv
// Shared types and constants for the basic-computer I/O controller.
package io_pkg;

    // Default character width for INPR/OUTR.
    localparam int unsigned DATA_W_DEF = 8;

    // Output-path handshake states.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } out_state_t;

    // Flag values seen right after reset.
    localparam logic FGO_RST = 1'b1;
    localparam logic FGI_RST = 1'b0;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO buffering input-device characters; head is read combinationally.
module io_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage write at the tail; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at AW bits; count tracks occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_interface.sv
// Basic-computer I/O controller: input FIFO (INPR/FGI), output register
// with device handshake (OUTR/FGO), overrun flag and interrupt request.
module io_interface
    import io_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] dev_in_data,
    input  logic              dev_in_valid,
    output logic              dev_in_ready,
    output logic [DATA_W-1:0] dev_out_data,
    output logic              dev_out_valid,
    input  logic              dev_out_ready,
    input  logic              inp_rd,
    input  logic              out_wr,
    input  logic [DATA_W-1:0] out_data,
    input  logic              IEN,
    output logic [DATA_W-1:0] INPR,
    output logic              FGI,
    output logic              FGO,
    output logic              irq,
    output logic              out_overrun
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_push;
    logic              fifo_pop;

    out_state_t        state_q;
    out_state_t        state_d;
    logic [DATA_W-1:0] outr_q;
    logic              load_outr;
    logic              overrun_set;

    // Ready is withheld while full even if a pop happens this cycle.
    assign dev_in_ready = ~fifo_full & ~reset;
    assign fifo_push    = dev_in_valid & dev_in_ready;
    assign fifo_pop     = inp_rd & FGI;

    io_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (dev_in_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head    (fifo_head)
    );

    assign FGI          = (fifo_count != '0);
    assign INPR         = fifo_empty ? '0 : fifo_head;
    assign dev_out_data = outr_q;
    assign irq          = IEN & (FGI | FGO);

    // Output FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output FSM next state, flags and load/overrun strobes.
    always_comb begin
        state_d       = state_q;
        FGO           = 1'b0;
        dev_out_valid = 1'b0;
        load_outr     = 1'b0;
        overrun_set   = 1'b0;
        case (state_q)
            IDLE: begin
                FGO = FGO_RST;
                if (out_wr) begin
                    load_outr = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                dev_out_valid = 1'b1;
                overrun_set   = out_wr;
                if (dev_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // OUTR holds its value after a transfer; overrun is sticky until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            outr_q      <= '0;
            out_overrun <= 1'b0;
        end else begin
            if (load_outr) begin
                outr_q <= out_data;
            end
            if (overrun_set) begin
                out_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_interface.sv
// Scoreboard bench for io_interface: stimulus queues expected INPR / OUTR
// characters, a monitor pops them on each input pop and output handshake.
module tb_io_interface;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] dev_in_data;
    logic       dev_in_valid;
    logic       dev_in_ready;
    logic [7:0] dev_out_data;
    logic       dev_out_valid;
    logic       dev_out_ready;
    logic       inp_rd;
    logic       out_wr;
    logic [7:0] out_data;
    logic       IEN;
    logic [7:0] INPR;
    logic       FGI;
    logic       FGO;
    logic       irq;
    logic       out_overrun;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    logic [7:0] in_q[$];
    logic [7:0] out_q[$];

    io_interface #(
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .dev_in_data   (dev_in_data),
        .dev_in_valid  (dev_in_valid),
        .dev_in_ready  (dev_in_ready),
        .dev_out_data  (dev_out_data),
        .dev_out_valid (dev_out_valid),
        .dev_out_ready (dev_out_ready),
        .inp_rd        (inp_rd),
        .out_wr        (out_wr),
        .out_data      (out_data),
        .IEN           (IEN),
        .INPR          (INPR),
        .FGI           (FGI),
        .FGO           (FGO),
        .irq           (irq),
        .out_overrun   (out_overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare popped INPR and transferred OUTR against the queues.
    always @(negedge clock) begin
        if (!reset) begin
            if (inp_rd && FGI) begin
                if (in_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL inpr_unexpected: got %h expected none", INPR);
                end else begin
                    check("inpr_pop", INPR, in_q.pop_front());
                end
            end
            if (dev_out_valid && dev_out_ready) begin
                if (out_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL outr_unexpected: got %h expected none", dev_out_data);
                end else begin
                    check("outr_xfer", dev_out_data, out_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; dev_in_data = '0; dev_in_valid = 1'b0; dev_out_ready = 1'b0;
        inp_rd = 1'b0; out_wr = 1'b0; out_data = '0; IEN = 1'b1;

        // Reset for two cycles
        tick(); tick();
        #2;
        check("rst_ready", {7'd0, dev_in_ready}, 8'd0);
        check("rst_fgi", {7'd0, FGI}, 8'd0);
        check("rst_fgo", {7'd0, FGO}, 8'd1);
        check("rst_valid", {7'd0, dev_out_valid}, 8'd0);
        check("rst_inpr", INPR, 8'h00);
        check("rst_outr", dev_out_data, 8'h00);
        check("rst_ovr", {7'd0, out_overrun}, 8'd0);
        check("rst_irq", {7'd0, irq}, 8'd1);
        tick();
        reset = 1'b0;
        #2;
        check("post_rst_ready", {7'd0, dev_in_ready}, 8'd1);

        // Fill the FIFO with four characters
        for (int i = 0; i < 4; i++) begin
            tick();
            dev_in_data = 8'h41 + 8'(i);
            dev_in_valid = 1'b1;
            in_q.push_back(8'h41 + 8'(i));
            #2;
            check("fill_ready", {7'd0, dev_in_ready}, 8'd1);
        end
        tick();
        dev_in_data = 8'h45;
        #2;
        check("full_ready", {7'd0, dev_in_ready}, 8'd0);
        check("full_head", INPR, 8'h41);
        check("full_fgi", {7'd0, FGI}, 8'd1);
        tick();
        inp_rd = 1'b1;
        #2;
        check("full_pop_ready", {7'd0, dev_in_ready}, 8'd0);
        tick();
        // 0x45 now accepted while the second pop happens
        in_q.push_back(8'h45);
        #2;
        check("after_pop_ready", {7'd0, dev_in_ready}, 8'd1);
        tick();
        dev_in_valid = 1'b0;
        tick(); tick(); tick();
        inp_rd = 1'b0;
        #2;
        check("drained_fgi", {7'd0, FGI}, 8'd0);
        check("drained_inpr", INPR, 8'h00);

        // Read while empty is ignored
        tick();
        inp_rd = 1'b1;
        #2;
        check("empty_rd_inpr", INPR, 8'h00);
        tick();
        inp_rd = 1'b0;
        #2;
        check("empty_rd_fgi", {7'd0, FGI}, 8'd0);

        // Simultaneous push/pop at count 1
        tick();
        dev_in_data = 8'h10; dev_in_valid = 1'b1; in_q.push_back(8'h10);
        tick();
        dev_in_data = 8'h20; inp_rd = 1'b1; in_q.push_back(8'h20);
        #2;
        check("pp_head_now", INPR, 8'h10);
        tick();
        dev_in_valid = 1'b0; inp_rd = 1'b0;
        #2;
        check("pp_head_next", INPR, 8'h20);
        check("pp_fgi", {7'd0, FGI}, 8'd1);
        tick();
        inp_rd = 1'b1;
        tick();
        inp_rd = 1'b0;
        #2;
        check("pp_count_one", {7'd0, FGI}, 8'd0);

        // Streaming across the pointer wrap (pointers sit at 3 here)
        tick();
        dev_in_data = 8'h31; dev_in_valid = 1'b1; in_q.push_back(8'h31);
        tick();
        dev_in_data = 8'h32; inp_rd = 1'b1; in_q.push_back(8'h32);
        tick();
        dev_in_data = 8'h33; in_q.push_back(8'h33);
        tick();
        dev_in_valid = 1'b0;
        tick();
        inp_rd = 1'b0;
        #2;
        check("wrap_empty", {7'd0, FGI}, 8'd0);

        // Output with backpressure
        tick();
        out_data = 8'h5A; out_wr = 1'b1; out_q.push_back(8'h5A);
        #2;
        check("idle_fgo", {7'd0, FGO}, 8'd1);
        tick();
        out_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("bp_valid", {7'd0, dev_out_valid}, 8'd1);
            check("bp_data", dev_out_data, 8'h5A);
            check("bp_fgo", {7'd0, FGO}, 8'd0);
            tick();
        end
        dev_out_ready = 1'b1;
        #2;
        check("hs_fgo", {7'd0, FGO}, 8'd0);
        tick();
        dev_out_ready = 1'b0;
        #2;
        check("post_hs_fgo", {7'd0, FGO}, 8'd1);
        check("post_hs_valid", {7'd0, dev_out_valid}, 8'd0);
        check("post_hs_ovr", {7'd0, out_overrun}, 8'd0);

        // Overrun
        tick();
        out_data = 8'h11; out_wr = 1'b1; out_q.push_back(8'h11);
        tick();
        out_data = 8'h22;
        #2;
        check("ovr_not_yet", {7'd0, out_overrun}, 8'd0);
        tick();
        out_wr = 1'b0;
        #2;
        check("ovr_set", {7'd0, out_overrun}, 8'd1);
        check("ovr_data_kept", dev_out_data, 8'h11);
        dev_out_ready = 1'b1;
        tick();
        dev_out_ready = 1'b0;
        out_data = 8'h33; out_wr = 1'b1; out_q.push_back(8'h33);
        tick();
        out_wr = 1'b0; dev_out_ready = 1'b1;
        #2;
        check("ovr_sticky", {7'd0, out_overrun}, 8'd1);
        tick();
        dev_out_ready = 1'b0;
        #2;
        check("ovr_sticky2", {7'd0, out_overrun}, 8'd1);
        check("ovr_fgo", {7'd0, FGO}, 8'd1);

        // Interrupt follows IEN combinationally
        tick();
        IEN = 1'b0;
        #1;
        check("irq_off", {7'd0, irq}, 8'd0);
        IEN = 1'b1;
        #1;
        check("irq_on", {7'd0, irq}, 8'd1);

        // Reset mid-SEND with three characters buffered
        tick();
        dev_in_data = 8'h61; dev_in_valid = 1'b1; out_data = 8'h77; out_wr = 1'b1;
        tick();
        dev_in_data = 8'h62; out_wr = 1'b0;
        #2;
        check("pre_rst_fgo", {7'd0, FGO}, 8'd0);
        check("pre_rst_irq", {7'd0, irq}, 8'd1);
        tick();
        dev_in_data = 8'h63;
        tick();
        dev_in_valid = 1'b0;
        #2;
        check("pre_rst_fgi", {7'd0, FGI}, 8'd1);
        check("pre_rst_valid", {7'd0, dev_out_valid}, 8'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        check("mid_rst_fgi", {7'd0, FGI}, 8'd0);
        check("mid_rst_inpr", INPR, 8'h00);
        check("mid_rst_fgo", {7'd0, FGO}, 8'd1);
        check("mid_rst_valid", {7'd0, dev_out_valid}, 8'd0);
        check("mid_rst_outr", dev_out_data, 8'h00);
        check("mid_rst_ovr", {7'd0, out_overrun}, 8'd0);

        tick();
        check("in_q_drained", 8'(in_q.size()), 8'd0);
        check("out_q_drained", 8'(out_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
